// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the writeback stage and its scoreboard.
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Register busy-bit scoreboard: tracks destination registers with writes still in flight.
module wb_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG = pipe_pkg::NREG
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    input  reg_addr_t issue_reg,
    input  logic      clr_valid,
    input  reg_addr_t clr_reg,
    input  logic      sb_clear,
    input  reg_addr_t chk_reg1,
    input  reg_addr_t chk_reg2,
    output logic      busy1,
    output logic      busy2
);

    logic [NREG-1:0] busy_q;

    // Busy bits: bulk clear beats everything, then a new issue beats a retiring write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else if (sb_clear) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (reg_addr_t'(r) == ZERO_REG) begin
                    busy_q[r] <= 1'b0;
                end else if (issue_valid && issue_reg == reg_addr_t'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if (clr_valid && clr_reg == reg_addr_t'(r)) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // A register being written this cycle is already visible through the register-file bypass.
    always_comb begin
        busy1 = busy_q[chk_reg1] & ~(clr_valid & (clr_reg == chk_reg1));
        busy2 = busy_q[chk_reg2] & ~(clr_valid & (clr_reg == chk_reg2));
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB latch, result select, single-shot register write under stall,
// retire counter and the register busy scoreboard.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int NREG   = pipe_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  reg_addr_t         mem_write_reg,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              issue_valid,
    input  reg_addr_t         issue_reg,
    input  logic              sb_clear,
    input  reg_addr_t         chk_reg1,
    input  reg_addr_t         chk_reg2,
    output logic              RegWrite,
    output reg_addr_t         write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_valid,
    output logic              busy1,
    output logic              busy2,
    output logic [31:0]       retire_cnt
);

    function automatic logic [DATA_W-1:0] wb_select(input logic to_reg,
                                                    input logic [DATA_W-1:0] load,
                                                    input logic [DATA_W-1:0] alu);
        return to_reg ? load : alu;
    endfunction

    logic              vld_p1;
    logic              done_p1;
    logic              reg_write_p1;
    logic              mem_to_reg_p1;
    reg_addr_t         write_reg_p1;
    logic [DATA_W-1:0] alu_p1;
    logic [DATA_W-1:0] load_p1;
    logic              capture;

    // Flush forces a capture (of a bubble) even while stalled.
    assign capture = ~stall | flush;

    // MEM -> WB boundary: control side (valid, write-once flag, retire count).
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            done_p1    <= 1'b0;
            retire_cnt <= '0;
        end else if (capture) begin
            vld_p1  <= mem_valid & ~flush;
            done_p1 <= 1'b0;
            if (mem_valid && !flush) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end else if (RegWrite) begin
            done_p1 <= 1'b1;
        end
    end

    // MEM -> WB boundary: data side, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            write_reg_p1  <= ZERO_REG;
            alu_p1        <= '0;
            load_p1       <= '0;
        end else if (capture) begin
            reg_write_p1  <= mem_reg_write;
            mem_to_reg_p1 <= mem_mem_to_reg;
            write_reg_p1  <= mem_write_reg;
            alu_p1        <= mem_alu_result;
            load_p1       <= mem_load_data;
        end
    end

    // Register-file write port; a held entry writes once, register 0 is never written.
    always_comb begin
        wb_valid   = vld_p1;
        write_reg  = write_reg_p1;
        write_data = wb_select(mem_to_reg_p1, load_p1, alu_p1);
        RegWrite   = vld_p1 & reg_write_p1 & (write_reg_p1 != ZERO_REG) & ~done_p1;
    end

    wb_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_reg  (issue_reg),
        .clr_valid  (RegWrite),
        .clr_reg    (write_reg_p1),
        .sb_clear   (sb_clear),
        .chk_reg1   (chk_reg1),
        .chk_reg2   (chk_reg2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver steps a behavioural model and queues the expected
// post-edge outputs; a monitor pops and compares after every rising edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, mem_reg_write = 1'b0, mem_mem_to_reg = 1'b0;
    logic [4:0]  mem_write_reg = '0;
    logic [31:0] mem_alu_result = '0, mem_load_data = '0;
    logic        stall = 1'b0, flush = 1'b0, issue_valid = 1'b0, sb_clear = 1'b0;
    logic [4:0]  issue_reg = '0, chk_reg1 = '0, chk_reg2 = '0;
    logic        RegWrite, wb_valid, busy1, busy2;
    logic [4:0]  write_reg;
    logic [31:0] write_data, retire_cnt;

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg(mem_write_reg),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .stall(stall), .flush(flush), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .sb_clear(sb_clear), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .wb_valid(wb_valid), .busy1(busy1), .busy2(busy2), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        mem_valid, reg_write, mem_to_reg;
        bit [4:0]  rd;
        bit [31:0] alu, load;
        bit        stall, flush, issue_valid, sb_clear;
        bit [4:0]  issue_reg, chk1, chk2;
    } stim_t;

    typedef struct {
        bit        wb_valid, regwrite, busy1, busy2;
        bit [4:0]  write_reg;
        bit [31:0] write_data, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: the entry currently sitting in writeback and the set of pending registers.
    bit        m_valid, m_rw, m_m2r, m_written;
    bit [4:0]  m_rd;
    bit [31:0] m_alu, m_load, m_cnt;
    bit [31:0] m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b1, default: '0};
        return s;
    endfunction

    task automatic drive(input stim_t s, input bit preload = 1'b0);
        bit   rw_now;
        bit   rw_new;
        exp_t e;
        @(negedge clk);
        if (preload) begin
            force dut.retire_cnt = 32'hFFFF_FFFE;
            #1;
            release dut.retire_cnt;
            m_cnt = 32'hFFFF_FFFE;
        end
        rst = s.rst; mem_valid = s.mem_valid; mem_reg_write = s.reg_write;
        mem_mem_to_reg = s.mem_to_reg; mem_write_reg = s.rd; mem_alu_result = s.alu;
        mem_load_data = s.load; stall = s.stall; flush = s.flush; issue_valid = s.issue_valid;
        issue_reg = s.issue_reg; sb_clear = s.sb_clear; chk_reg1 = s.chk1; chk_reg2 = s.chk2;

        rw_now = m_valid && m_rw && m_rd != 0 && !m_written;
        if (!s.rst) begin
            {m_valid, m_rw, m_m2r, m_written} = '0;
            m_rd = '0; m_alu = '0; m_load = '0; m_cnt = '0; m_busy = '0;
        end else begin
            if (s.sb_clear) m_busy = '0;
            else begin
                if (rw_now) m_busy[m_rd] = 1'b0;
                if (s.issue_valid && s.issue_reg != 0) m_busy[s.issue_reg] = 1'b1;
            end
            if (s.flush || !s.stall) begin
                m_valid = s.mem_valid && !s.flush;
                m_rw = s.reg_write; m_m2r = s.mem_to_reg; m_rd = s.rd;
                m_alu = s.alu; m_load = s.load; m_written = 1'b0;
                if (m_valid) m_cnt = m_cnt + 1;
            end else if (rw_now) begin
                m_written = 1'b1;
            end
        end
        rw_new       = m_valid && m_rw && m_rd != 0 && !m_written;
        e.wb_valid   = m_valid;
        e.regwrite   = rw_new;
        e.write_reg  = m_rd;
        e.write_data = m_m2r ? m_load : m_alu;
        e.busy1      = m_busy[s.chk1] && !(rw_new && m_rd == s.chk1);
        e.busy2      = m_busy[s.chk2] && !(rw_new && m_rd == s.chk2);
        e.cnt        = m_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_valid",   {31'b0, wb_valid}, {31'b0, e.wb_valid});
            check("RegWrite",   {31'b0, RegWrite}, {31'b0, e.regwrite});
            check("write_reg",  {27'b0, write_reg}, {27'b0, e.write_reg});
            check("write_data", write_data, e.write_data);
            check("busy1",      {31'b0, busy1}, {31'b0, e.busy1});
            check("busy2",      {31'b0, busy2}, {31'b0, e.busy2});
            check("retire_cnt", retire_cnt, e.cnt);
        end
    end

    initial begin
        stim_t s;
        int    q_left;
        // Reset state
        s = idle(); s.rst = 1'b0;
        drive(s); drive(s);

        // ALU result writeback
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 5; s.alu = 32'h1234;
        drive(s); drive(idle());

        // Load data to r0: data selected but no write
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.mem_to_reg = 1; s.rd = 0;
        s.load = 32'hDEAD_BEEF; s.alu = 32'h5555;
        drive(s); drive(idle());

        // Held entry writes exactly once
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 9; s.alu = 32'hCAFE_0009;
        drive(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1; s.mem_valid = 1; s.reg_write = 1; s.rd = 12; s.alu = i;
            drive(s);
        end
        drive(idle());

        // Flush beats stall
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 3; s.alu = 32'h33;
        drive(s);
        s = idle(); s.stall = 1; s.flush = 1; s.mem_valid = 1; s.reg_write = 1; s.rd = 4;
        drive(s); drive(idle());

        // Scoreboard: issue, bypassed clear, set beats clear
        s = idle(); s.issue_valid = 1; s.issue_reg = 7; s.chk1 = 7;
        drive(s);
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 7; s.alu = 32'h77; s.chk1 = 7;
        drive(s);
        s = idle(); s.issue_valid = 1; s.issue_reg = 7; s.chk1 = 7; s.chk2 = 7;
        drive(s);
        s = idle(); s.chk1 = 7; s.chk2 = 0;
        drive(s);
        // Bulk clear overrides a same-cycle issue
        s = idle(); s.issue_valid = 1; s.issue_reg = 3; s.sb_clear = 1; s.chk1 = 7; s.chk2 = 3;
        drive(s);
        // Issue to r0 never marks busy
        s = idle(); s.issue_valid = 1; s.issue_reg = 0; s.chk1 = 0;
        drive(s); drive(s);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst         = ($urandom_range(0, 59) != 0);
            s.mem_valid   = $urandom_range(0, 3) != 0;
            s.reg_write   = $urandom_range(0, 3) != 0;
            s.mem_to_reg  = $urandom_range(0, 1);
            s.rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.alu         = $urandom;
            s.load        = $urandom;
            s.stall       = $urandom_range(0, 2) == 0;
            s.flush       = $urandom_range(0, 7) == 0;
            s.issue_valid = $urandom_range(0, 1);
            s.issue_reg   = 5'($urandom_range(0, 31));
            s.sb_clear    = $urandom_range(0, 24) == 0;
            s.chk1        = ($urandom_range(0, 1) != 0) ? s.rd : 5'($urandom_range(0, 31));
            s.chk2        = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
            drive(s);
        end

        // Reset in the middle of a stall clears everything
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 17; s.alu = 32'h1717;
        s.issue_valid = 1; s.issue_reg = 17; s.chk1 = 17;
        drive(s);
        s = idle(); s.stall = 1; s.chk1 = 17;
        drive(s);
        s = idle(); s.rst = 0; s.stall = 1; s.flush = 1; s.issue_valid = 1; s.issue_reg = 9;
        s.sb_clear = 1; s.chk1 = 9;
        drive(s);

        // Counter wrap from 0xFFFFFFFF to 0
        drive(idle(), 1'b1);
        s = idle(); s.mem_valid = 1; s.reg_write = 1; s.rd = 2; s.alu = 32'h2;
        drive(s); drive(s); drive(idle());

        @(negedge clk);
        @(negedge clk);
        q_left = exp_q.size();
        check("scoreboard_drained", q_left, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
